// File: rtl/bcd2bin.sv
// bcd2bin: sequential 4-digit BCD to 10-bit binary converter.
// Captures the four digits on an accepted start and then runs one
// multiply-accumulate step per digit, thousands first. A final cycle
// classifies the result (bad digit / overflow / ok) and pulses done.
module bcd2bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mil,
  input  logic [3:0] cent,
  input  logic [3:0] dec,
  input  logic [3:0] un,
  output logic [9:0] b_out,
  output logic       busy,
  output logic       done,
  output logic       err_digit,
  output logic       err_ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, FIN = 2'd2} state_t;

  state_t           state_q, state_d;
  // dig_q[0] is the thousands digit, dig_q[3] the units digit
  logic [3:0][3:0]  dig_q, dig_d;
  logic [13:0]      acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  logic [9:0]       b_out_q, b_out_d;
  logic             done_q, done_d;
  logic             err_digit_q, err_digit_d;
  logic             err_ovf_q, err_ovf_d;

  logic             dig_bad;
  logic [13:0]      acc_step;

  // A captured digit above 9 makes the whole conversion invalid
  always_comb begin
    dig_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dig_q[i] > 4'd9) dig_bad = 1'b1;
    end
  end

  // One Horner step: acc*10 + current digit; 9999 fits in 14 bits for valid digits
  assign acc_step = (acc_q * 14'd10) + {10'd0, dig_q[idx_q]};

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    dig_d       = dig_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    b_out_d     = b_out_q;
    done_d      = 1'b0;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dig_d[0] = mil;
          dig_d[1] = cent;
          dig_d[2] = dec;
          dig_d[3] = un;
          acc_d    = 14'd0;
          idx_d    = 2'd0;
          state_d  = CONV;
        end
      end
      CONV: begin
        acc_d = acc_step;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dig_bad) begin
          b_out_d     = 10'd0;
          err_digit_d = 1'b1;
          err_ovf_d   = 1'b0;
        end else if (acc_q > 14'd1023) begin
          b_out_d     = 10'd1023;
          err_digit_d = 1'b0;
          err_ovf_d   = 1'b1;
        end else begin
          b_out_d     = acc_q[9:0];
          err_digit_d = 1'b0;
          err_ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dig_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      b_out_q     <= '0;
      done_q      <= 1'b0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      b_out_q     <= b_out_d;
      done_q      <= done_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign b_out     = b_out_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: directed vectors for bcd2bin. Stimulus pushes the expected
// {b_out, err_digit, err_ovf} into a queue; a monitor pops and compares
// on every done pulse. Stimulus tasks also check the busy/done timing.
module tb_bcd2bin;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] mil, cent, dec, un;
  logic [9:0] b_out;
  logic       busy, done, err_digit, err_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  bcd2bin dut (
    .clk(clk), .rst(rst), .start(start),
    .mil(mil), .cent(cent), .dec(dec), .un(un),
    .b_out(b_out), .busy(busy), .done(done),
    .err_digit(err_digit), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("b_out", {22'd0, b_out}, {22'd0, e[11:2]});
        chk("err_digit", {31'd0, err_digit}, {31'd0, e[1]});
        chk("err_ovf", {31'd0, err_ovf}, {31'd0, e[0]});
      end
    end
  end

  // Single conversion with a full busy/done timing check; digits are
  // scrambled right after capture so a late sample would corrupt the result
  task automatic run_conv(input logic [3:0] m, c, d, u,
                          input logic [9:0] eb, input logic ed, input logic eo);
    @(negedge clk);
    mil = m; cent = c; dec = d; un = u; start = 1'b1;
    exp_q.push_back({eb, ed, eo});
    @(posedge clk); #1;
    start = 1'b0;
    mil = ~m; cent = ~c; dec = ~d; un = ~u;
    for (int i = 0; i < 5; i++) begin
      chk("busy_during_conv", {31'd0, busy}, 32'd1);
      chk("done_during_conv", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("busy_in_done_cycle", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("done_cleared", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0;
    mil = 4'd0; cent = 4'd0; dec = 4'd0; un = 4'd0;
    #23;
    chk("rst_b_out", {22'd0, b_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err_digit", {31'd0, err_digit}, 32'd0);
    chk("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Nominal and overflow boundary cases
    run_conv(4'd0, 4'd5, 4'd2, 4'd7, 10'd527,  1'b0, 1'b0);
    run_conv(4'd1, 4'd0, 4'd2, 4'd3, 10'd1023, 1'b0, 1'b0);
    run_conv(4'd1, 4'd0, 4'd2, 4'd4, 10'd1023, 1'b0, 1'b1);
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 10'd1023, 1'b0, 1'b1);
    // Invalid digit, then recovery
    run_conv(4'd0, 4'd1, 4'hA, 4'd3, 10'd0,    1'b1, 1'b0);
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, 10'd42,   1'b0, 1'b0);
    // Invalid digit has priority over what would be an overflow
    run_conv(4'hF, 4'd9, 4'd9, 4'd9, 10'd0,    1'b1, 1'b0);

    // start held high for 12 edges: accepts at N and N+6 only
    base = done_cnt;
    @(negedge clk);
    mil = 4'd0; cent = 4'd1; dec = 4'd2; un = 4'd3; start = 1'b1;
    exp_q.push_back({10'd123, 1'b0, 1'b0});
    exp_q.push_back({10'd456, 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin mil = 4'd0; cent = 4'd4; dec = 4'd5; un = 4'd6; end
      if (i == 5) chk("held_start_done_cycle_idle", {31'd0, busy}, 32'd0);
      if (i == 6) begin
        chk("held_start_reaccepted", {31'd0, busy}, 32'd1);
        mil = 4'd9; cent = 4'd8; dec = 4'd7; un = 4'd6;
      end
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held_start_conversions", done_cnt - base, 32'd2);
    chk("held_start_idle_after", {31'd0, busy}, 32'd0);

    // Reset at N+2 of a 9,0,0,0 conversion aborts it silently
    base = done_cnt;
    @(negedge clk);
    mil = 4'd9; cent = 4'd0; dec = 4'd0; un = 4'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("abort_b_out", {22'd0, b_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err_digit", {31'd0, err_digit}, 32'd0);
    chk("abort_err_ovf", {31'd0, err_ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 32'd0);
    chk("abort_still_idle", {31'd0, busy}, 32'd0);
    run_conv(4'd0, 4'd0, 4'd0, 4'd9, 10'd9, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
